// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: phase, colour and monitor state types shared by the traffic light blocks
package traffic_light_pkg;
  typedef enum logic [1:0] {PH_G1R2 = 2'd0, PH_Y1R2 = 2'd1, PH_R1G2 = 2'd2, PH_R1Y2 = 2'd3} phase_e;
  typedef enum logic [1:0] {COL_R = 2'd0, COL_Y = 2'd1, COL_G = 2'd2} colour_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SYNC_WAIT = 2'd1, ST_TRACK = 2'd2} mon_state_e;
  function automatic phase_e next_phase(input phase_e p);
    return phase_e'(p + 2'd1);
  endfunction
endpackage

// File: rtl/lamp_decode.sv
// lamp_decode: maps one light's three lamps to a colour, valid only when exactly one lamp is lit
module lamp_decode
  import traffic_light_pkg::*;
(
  input  logic    red,
  input  logic    yellow,
  input  logic    green,
  output colour_e colour,
  output logic    valid
);
  always_comb begin
    colour = green ? COL_G : yellow ? COL_Y : COL_R;
    valid  = (red + yellow + green) == 2'd1;
  end
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: decodes lamp outputs into phases and flags safety, order and dwell violations
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int GREEN_CYCLES  = 250000000,
  parameter int YELLOW_CYCLES = 100000000,
  parameter int CNT_W         = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        red1,
  input  logic        yellow1,
  input  logic        green1,
  input  logic        red2,
  input  logic        yellow2,
  input  logic        green2,
  output logic [1:0]  phase,
  output logic        phase_valid,
  output logic [15:0] cycle_count,
  output logic        err_illegal,
  output logic        err_conflict,
  output logic        err_sequence,
  output logic        err_timing,
  output logic        err_any
);
  localparam logic [CNT_W-1:0] G_DWELL = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] Y_DWELL = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] SAT     = CNT_W'(GREEN_CYCLES + 1);
  colour_e c1, c2;
  logic v1, v2;
  lamp_decode u_light1 (.red(red1), .yellow(yellow1), .green(green1), .colour(c1), .valid(v1));
  lamp_decode u_light2 (.red(red2), .yellow(yellow2), .green(green2), .colour(c2), .valid(v2));
  mon_state_e state_q, state_d;
  phase_e phase_q, phase_d, smp;
  logic phase_valid_q, phase_valid_d;
  logic [15:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, dwell_inc, dwell_exp;
  logic [3:0] err_q, err_d;
  logic err_any_q, err_any_d;
  logic ill, conf, all_red;
  // err bits: {illegal, conflict, sequence, timing}
  always_comb begin
    ill       = !v1 || !v2;
    conf      = !ill && c1 != COL_R && c2 != COL_R;
    all_red   = !ill && c1 == COL_R && c2 == COL_R;
    smp       = c1 == COL_G ? PH_G1R2 : c1 == COL_Y ? PH_Y1R2 : c2 == COL_G ? PH_R1G2 : PH_R1Y2;
    dwell_exp = phase_q[0] ? Y_DWELL : G_DWELL;
    dwell_inc = dwell_q == SAT ? dwell_q : dwell_q + CNT_W'(1);
    state_d       = state_q;
    phase_d       = phase_q;
    phase_valid_d = phase_valid_q;
    cycle_d       = cycle_q;
    dwell_d       = dwell_q;
    err_d         = err_q;
    if (ill || conf || all_red) begin
      err_d         = err_q | {ill, conf, all_red, 1'b0};
      state_d       = ST_SYNC_WAIT;
      phase_valid_d = 1'b0;
    end else if (state_q == ST_IDLE || !phase_valid_q) begin
      phase_d       = smp;
      phase_valid_d = 1'b1;
      dwell_d       = CNT_W'(1);
      state_d       = ST_SYNC_WAIT;
    end else if (smp == phase_q) begin
      dwell_d = dwell_inc;
      if (state_q == ST_TRACK && dwell_q == dwell_exp) begin
        err_d[0] = 1'b1;
        state_d  = ST_SYNC_WAIT;
      end
    end else if (smp == next_phase(phase_q)) begin
      phase_d = smp;
      dwell_d = CNT_W'(1);
      if (state_q != ST_TRACK) state_d = ST_TRACK;
      else if (dwell_q != dwell_exp) begin
        err_d[0] = 1'b1;
        state_d  = ST_SYNC_WAIT;
      end else if (phase_q == PH_R1Y2) cycle_d = cycle_q + 16'd1;
    end else begin
      err_d[1] = 1'b1;
      phase_d  = smp;
      dwell_d  = CNT_W'(1);
      state_d  = ST_SYNC_WAIT;
    end
    err_any_d = |err_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_G1R2;
      phase_valid_q <= 1'b0;
      cycle_q       <= '0;
      dwell_q       <= '0;
      err_q         <= '0;
      err_any_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      cycle_q       <= cycle_d;
      dwell_q       <= dwell_d;
      err_q         <= err_d;
      err_any_q     <= err_any_d;
    end
  end
  assign phase        = phase_q;
  assign phase_valid  = phase_valid_q;
  assign cycle_count  = cycle_q;
  assign err_illegal  = err_q[3];
  assign err_conflict = err_q[2];
  assign err_sequence = err_q[1];
  assign err_timing   = err_q[0];
  assign err_any      = err_any_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: scenario tasks with a scoreboard of expected monitor outputs
module tb_traffic_light_monitor;
  localparam int GC = 30;
  localparam int YC = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic red1, yellow1, green1, red2, yellow2, green2;
  logic [1:0] phase;
  logic phase_valid, err_illegal, err_conflict, err_sequence, err_timing, err_any;
  logic [15:0] cycle_count;
  typedef struct { logic [23:0] v; string nm; } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  traffic_light_monitor #(.GREEN_CYCLES(GC), .YELLOW_CYCLES(YC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .red1(red1), .yellow1(yellow1), .green1(green1),
    .red2(red2), .yellow2(yellow2), .green2(green2),
    .phase(phase), .phase_valid(phase_valid), .cycle_count(cycle_count),
    .err_illegal(err_illegal), .err_conflict(err_conflict), .err_sequence(err_sequence),
    .err_timing(err_timing), .err_any(err_any)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] lamps(input int ph);
    case (ph)
      0: return 6'b001_100;
      1: return 6'b010_100;
      2: return 6'b100_001;
      default: return 6'b100_010;
    endcase
  endfunction
  function automatic logic [23:0] obs();
    return {phase, phase_valid, cycle_count, err_illegal, err_conflict, err_sequence, err_timing, err_any};
  endfunction
  function automatic exp_t mk(input string nm, input logic [1:0] ph, input logic pv, input logic [15:0] cc,
                              input logic ei, input logic ec, input logic es, input logic et);
    exp_t r;
    r.v  = {ph, pv, cc, ei, ec, es, et, ei | ec | es | et};
    r.nm = nm;
    return r;
  endfunction
  task automatic step(input logic [5:0] l);
    {red1, yellow1, green1, red2, yellow2, green2} = l;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int ph, input int n);
    repeat (n) step(lamps(ph));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(lamps(0));
    rst = 1'b0;
  endtask
  task automatic run_cycles(input int n);
    repeat (n) begin
      run(0, GC); run(1, YC); run(2, GC); run(3, YC);
    end
  endtask
  task automatic test_reset();
    sb.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    step(6'b111_111);
    rst = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
  endtask
  task automatic test_legal();
    do_reset();
    sb.push_back(mk("first_p0", 0, 1, 0, 0, 0, 0, 0));
    run(0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    run(0, GC - 1); run(1, YC); run(2, GC); run(3, YC);
    sb.push_back(mk("first_wrap", 0, 1, 1, 0, 0, 0, 0));
    run(0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    run(0, GC - 1); run(1, YC); run(2, GC); run(3, YC);
    run_cycles(1);
    sb.push_back(mk("three_wraps", 0, 1, 3, 0, 0, 0, 0));
    run(0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
  endtask
  task automatic test_overrun();
    run(0, GC - 2);
    sb.push_back(mk("green_exact", 0, 1, 3, 0, 0, 0, 0));
    run(0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    sb.push_back(mk("green_overrun", 0, 1, 3, 0, 0, 0, 1));
    run(0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    do_reset();
    run_cycles(1);
    run(0, GC); run(1, YC - 2);
    sb.push_back(mk("yellow_short_hold", 1, 1, 1, 0, 0, 0, 0));
    run(1, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    sb.push_back(mk("yellow_short", 2, 1, 1, 0, 0, 0, 1));
    run(2, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
  endtask
  task automatic test_conflict();
    do_reset();
    run(0, 3);
    sb.push_back(mk("conflict", 0, 0, 0, 0, 1, 0, 0));
    step(6'b001_001);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
  endtask
  task automatic test_illegal();
    sb.push_back(mk("illegal", 0, 0, 0, 1, 1, 0, 0));
    step(6'b011_100);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    sb.push_back(mk("all_red", 0, 0, 0, 1, 1, 1, 0));
    step(6'b100_100);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    run_cycles(2);
    run(0, GC); run(1, YC); run(2, 24);
    sb.push_back(mk("sticky_200", 2, 1, 2, 1, 1, 1, 0));
    run(2, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
  endtask
  task automatic test_jump();
    do_reset();
    run_cycles(1);
    run(0, 10);
    sb.push_back(mk("jump_p0_p2", 2, 1, 1, 0, 0, 1, 0));
    run(2, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    run(2, GC - 1); run(3, YC);
    sb.push_back(mk("resume_count", 0, 1, 2, 0, 0, 1, 0));
    run(0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
  endtask
  task automatic test_reset_mid();
    run(0, GC - 1); run(1, YC); run(2, 10);
    sb.push_back(mk("reset_mid_p2", 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    run(2, 1);
    rst = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    run(2, 10); run(3, YC);
    run(0, GC); run(1, YC); run(2, GC); run(3, YC);
    sb.push_back(mk("partial_untimed", 0, 1, 2, 0, 0, 0, 0));
    run(0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
  endtask
  initial begin
    {red1, yellow1, green1, red2, yellow2, green2} = 6'b0;
    test_reset();
    test_legal();
    test_overrun();
    test_conflict();
    test_illegal();
    test_jump();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
